// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF neuron and its synapse front end.
package lif_pkg;

    localparam int unsigned LIF_WIDTH      = 8;
    localparam int unsigned DEFAULT_WEIGHT = 32;

    // Current and weight values share one unsigned type.
    typedef logic [LIF_WIDTH-1:0] lif_val_t;

    // Unsigned add that clamps at full scale instead of wrapping.
    function automatic lif_val_t sat_add(input lif_val_t a, input lif_val_t b);
        logic [LIF_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[LIF_WIDTH] ? {LIF_WIDTH{1'b1}} : sum[LIF_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge detector over a vector of spike levels.
// History updates every cycle so a held level yields exactly one event.
module spike_edge_detect #(
    parameter int unsigned NUM = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NUM-1:0] level,
    output logic [NUM-1:0] rise
);

    logic [NUM-1:0] prev_q;

    // Level history; cleared by reset so an already-high input counts once.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/spike_synapse.sv
// Presynaptic front end: weighted spike events feed a decaying, saturating
// synaptic current register that drives the neuron's current input.
module spike_synapse
    import lif_pkg::*;
#(
    parameter int unsigned WIDTH          = lif_pkg::LIF_WIDTH,
    parameter int unsigned NUM_IN         = 4,
    parameter int unsigned DECAY_SHIFT    = 3,
    parameter int unsigned DECAY_PERIOD   = 16,
    parameter int unsigned DEFAULT_WEIGHT = lif_pkg::DEFAULT_WEIGHT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [NUM_IN-1:0]         spike_in,
    input  logic                      cfg_valid,
    input  logic [$clog2(NUM_IN)-1:0] cfg_addr,
    input  logic [WIDTH-1:0]          cfg_data,
    output logic                      cfg_ready,
    output logic [WIDTH-1:0]          current,
    output logic                      sat,
    input  logic                      sat_clr
);

    localparam int unsigned AW = $clog2(NUM_IN);
    localparam int unsigned SW = WIDTH + AW;   // event sum never overflows
    localparam int unsigned NW = SW + 1;       // headroom for current + sum
    localparam int unsigned CW = $clog2(DECAY_PERIOD);

    localparam logic [CW-1:0] LAST_CNT = CW'(DECAY_PERIOD - 1);
    localparam logic [NW-1:0] MAX_N    = {{(NW-WIDTH){1'b0}}, {WIDTH{1'b1}}};
    localparam logic [AW:0]   NUM_IN_W = (AW+1)'(NUM_IN);
    localparam logic [WIDTH-1:0] DEF_W = WIDTH'(DEFAULT_WEIGHT);

    logic [WIDTH-1:0]  weight_q [NUM_IN];
    logic [WIDTH-1:0]  current_q, current_d;
    logic [CW-1:0]     decay_cnt_q;
    logic              sat_q;
    logic              rdy_q;
    logic [NUM_IN-1:0] ev;
    logic [SW-1:0]     ev_sum;
    logic [WIDTH-1:0]  decay;
    logic [NW-1:0]     n_full;
    logic              tick;
    logic              over;
    logic              wr_en;

    spike_edge_detect #(
        .NUM(NUM_IN)
    ) u_edge (
        .clk  (clk),
        .rst  (rst),
        .level(spike_in),
        .rise (ev)
    );

    // rdy_q marks that a reset has been seen; ready is low while rst is held.
    assign cfg_ready = rdy_q & ~rst;
    assign wr_en     = cfg_valid & cfg_ready & ({1'b0, cfg_addr} < NUM_IN_W);

    // Ready tracking: set by the first reset, never cleared.
    always_ff @(posedge clk) begin
        rdy_q <= rdy_q | rst;
    end

    // Weight registers; writes land after this cycle's event sum is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                weight_q[i] <= DEF_W;
            end
        end else if (wr_en) begin
            weight_q[cfg_addr] <= cfg_data;
        end
    end

    // Sum of weights for every channel with an event this cycle.
    always_comb begin
        ev_sum = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (ev[i]) begin
                ev_sum = ev_sum + SW'(weight_q[i]);
            end
        end
    end

    // Decay first, then add events, then clamp to full scale.
    always_comb begin
        tick      = (decay_cnt_q == LAST_CNT);
        decay     = tick ? (current_q >> DECAY_SHIFT) : '0;
        n_full    = NW'(current_q - decay) + NW'(ev_sum);
        over      = (n_full > MAX_N);
        current_d = over ? {WIDTH{1'b1}} : n_full[WIDTH-1:0];
    end

    // Current, decay timer and sticky saturation; all frozen while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            current_q   <= '0;
            decay_cnt_q <= '0;
            sat_q       <= 1'b0;
        end else if (ena) begin
            current_q   <= current_d;
            decay_cnt_q <= tick ? '0 : decay_cnt_q + CW'(1);
            if (over) begin
                sat_q <= 1'b1;
            end else if (sat_clr) begin
                sat_q <= 1'b0;
            end
        end
    end

    assign current = current_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_spike_synapse.sv
// Directed bench for spike_synapse with hand-computed expected values.
module tb_spike_synapse;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [3:0] spike_in;
    logic       cfg_valid;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic [7:0] current;
    logic       sat;
    logic       sat_clr;

    int checks   = 0;
    int failures = 0;

    spike_synapse dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .spike_in (spike_in),
        .cfg_valid(cfg_valid),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_ready(cfg_ready),
        .current  (current),
        .sat      (sat),
        .sat_clr  (sat_clr)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; spike_in = '0; cfg_valid = 1'b0;
        cfg_addr = '0; cfg_data = '0; sat_clr = 1'b0;

        // Reset state
        step(2);
        check("rst_current", 32'(current), 0);
        check("rst_sat", 32'(sat), 0);
        check("rst_ready", 32'(cfg_ready), 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(cfg_ready), 1);

        // Single held edge: one event of default weight 32
        spike_in = 4'b0001;
        step(1);
        check("first_edge", 32'(current), 32);
        step(4);
        check("held_level", 32'(current), 32);
        spike_in = '0;
        step(10);                      // through edge 15, no tick yet
        check("pre_tick", 32'(current), 32);
        step(1);                       // edge 16 ticks
        check("decay_1", 32'(current), 28);
        step(16);
        check("decay_2", 32'(current), 25);
        step(16);
        check("decay_3", 32'(current), 22);

        // Tick and event in the same cycle
        do_reset();
        spike_in = 4'b0001;
        step(1);
        spike_in = '0;
        step(14);
        check("tick_ev_pre", 32'(current), 32);
        spike_in = 4'b0010;
        step(1);
        check("tick_plus_event", 32'(current), 60);
        spike_in = '0;

        // Decay fixed point at 7
        do_reset();
        cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 8'd7;
        step(1);
        cfg_valid = 1'b0;
        spike_in = 4'b0100;
        step(1);
        check("small_weight", 32'(current), 7);
        spike_in = '0;
        step(14);
        check("fixed_pt_tick1", 32'(current), 7);
        step(16);
        check("fixed_pt_tick2", 32'(current), 7);

        // Saturation and sticky flag
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1; cfg_addr = 2'(i); cfg_data = 8'd200;
            step(1);
        end
        cfg_valid = 1'b0;
        spike_in = 4'b1111;
        step(1);
        check("sat_current", 32'(current), 255);
        check("sat_set", 32'(sat), 1);
        spike_in = '0; sat_clr = 1'b1;
        step(1);
        check("sat_cleared", 32'(sat), 0);
        check("sat_hold_current", 32'(current), 255);
        spike_in = 4'b1111;
        step(1);
        check("sat_set_wins", 32'(sat), 1);
        spike_in = '0; sat_clr = 1'b0;

        // Write/event collision, then mid-run reset
        do_reset();
        check("rst_clears_sat", 32'(sat), 0);
        cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_data = 8'd100;
        spike_in = 4'b0010;
        step(1);
        check("collision_old_w", 32'(current), 32);
        cfg_valid = 1'b0; spike_in = '0;
        step(1);
        spike_in = 4'b0010;
        step(1);
        check("new_weight", 32'(current), 132);
        spike_in = '0;
        cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd18;
        step(1);
        cfg_valid = 1'b0; spike_in = 4'b0001;
        step(1);
        check("reach_150", 32'(current), 150);
        spike_in = '0;
        do_reset();
        #1;
        check("midrun_rst_current", 32'(current), 0);
        spike_in = 4'b0010;
        step(1);
        check("weight_restored", 32'(current), 32);
        spike_in = '0;
        step(14);
        check("cnt_restart_pre", 32'(current), 32);
        step(1);
        check("cnt_restart_tick", 32'(current), 28);

        // ena low freezes current but history still tracks the level
        ena = 1'b0; spike_in = 4'b0001;
        step(1);
        check("ena_freeze", 32'(current), 28);
        ena = 1'b1;
        step(1);
        check("ena_history", 32'(current), 28);
        spike_in = '0;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_synapse.md
Name: spike_synapse

Overview:
- Presynaptic front end for the LIF neuron: converts incoming spike events into the 8-bit input current that the neuron consumes.
- Each of NUM_IN spike channels has a programmable weight.
- A spike event adds its channel's weight to a synaptic current register. The register decays exponentially on a fixed tick and saturates at full scale.
- Output `current` connects directly to the neuron's current input.

Parameters:
- WIDTH, 8, width of weights and of the output current
- NUM_IN, 4, number of presynaptic spike channels
- DECAY_SHIFT, 3, decay amount per tick is current >> DECAY_SHIFT
- DECAY_PERIOD, 16, clock cycles between decay ticks (must be >= 2)
- DEFAULT_WEIGHT, 32, weight loaded into every channel on reset

Ports:
- clk  in  1  clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  when low, current, decay counter and sat are frozen; config writes and edge-history updates still occur
- spike_in  in  NUM_IN  presynaptic spike levels; a rising edge is one event
- cfg_valid  in  1  weight-write request
- cfg_addr  in  $clog2(NUM_IN)  channel index to write
- cfg_data  in  WIDTH  new weight (unsigned)
- cfg_ready  out  1  weight-write acceptance
- current  out  WIDTH  synaptic current, registered, unsigned
- sat  out  1  sticky flag: the current has clamped at least once
- sat_clr  in  1  clears sat

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: current=0, sat=0, spike_prev=0, decay_cnt=0, all weights=DEFAULT_WEIGHT, cfg_ready=0 during reset.
- cfg_ready is 1 in every cycle after reset deasserts. A write occurs when cfg_valid & cfg_ready at an edge.
- Event detection: ev[i] = spike_in[i] & ~spike_prev[i]; spike_prev <= spike_in every cycle, independent of ena. A level held high gives exactly one event. The first cycle after reset with spike_in already high counts as an event.
- Event sum: S = sum of weights[i] for all asserted ev[i]. S is WIDTH+$clog2(NUM_IN) bits and must not overflow (max 1020 at defaults).
- Decay tick: tick = (decay_cnt == DECAY_PERIOD-1). decay_cnt increments and wraps to 0 after DECAY_PERIOD-1, only while ena=1.
- Update, only when ena=1:
  - D = tick ? (current >> DECAY_SHIFT) : 0
  - N = current - D + S, computed at full width
  - current <= min(N, 2^WIDTH-1)
- Decay is applied before the addition in the same cycle; a tick and an event in one cycle are both applied.
- Latency: an event sampled at edge k is visible on `current` after edge k (one-cycle latency).
- Saturation:
  - If N > 2^WIDTH-1 (with ena=1), sat <= 1.
  - sat_clr clears sat at the edge.
  - If clamping and sat_clr occur in the same cycle, set wins and sat=1.
- Weight-write collision: if channel j is written in the same cycle as an event on j, S uses the old weight. The new weight applies from the next cycle.
- Write to a channel index >= NUM_IN: ignored, with no side effects.
- Decay fixed point: at DECAY_SHIFT=3, values < 8 do not decay further (current>>3 = 0). This is required behaviour; no rounding.
- Reset mid-operation: all state returns to reset values at that edge, including programmed weights.

Decomposition:
- Shared package lif_pkg:
  - LIF_WIDTH = 8
  - DEFAULT_WEIGHT
  - typedef for the current/weight type
  - a sat_add function (unsigned saturating clamp)
- The neuron and the synapse both import lif_pkg.
- Sub-module spike_edge_detect (NUM_IN wide, registered history plus ev output). It is reusable for the neuron's spike output monitor.
- Weight storage is a flat register array inside spike_synapse; no RAM.

Test Plan:
- Reset: assert rst 2 cycles -> current=0, sat=0, cfg_ready=0. Release -> cfg_ready=1. An event on ch0 adds 32, confirming default weights.
- Single edge: spike_in[0] high for 5 cycles from current=0, decay not ticking -> current=32 after the first edge, unchanged for the remaining 4 cycles.
- Decay: current=32, no events -> next tick 28, following tick 25, then 22. At current=7, ticks leave it at 7.
- Tick plus event same cycle: current=32, event ch1 (w=32) on the tick cycle -> current=60.
- Saturation: write weights 200 to ch0..3, then pulse all 4 -> current=255, sat=1. sat_clr alone -> sat=0. A repeated clamping event together with sat_clr -> sat stays 1.
- Collision and reset: write ch1=100 in the same cycle as a ch1 event -> +32; the next ch1 event adds +100. With current=150, one rst cycle -> current=0, weight ch1 back to 32, decay_cnt=0.
